aes_serial_seq: RTL

// Parametrised sequencer for the narrow-path AES-128 encrypt engine; next generation of the fixed 8-bit controller.

---
 rtl/aes_serial_seq.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/aes_serial_seq.sv
// ----------------------------------------------------------------------------
// aes_serial_seq
//   Control sequencer for the narrow-path AES-128 encrypt engine. It produces
//   the key-expansion selects and the datapath enables for a 1, 2 or 4
//   byte-per-cycle datapath and a configurable number of rounds. Data and key
//   buses never pass through this block; only the handshake and the select
//   lines do.
//
//   Handshake rule (both sides): a beat transfers on a rising clk edge where
//   valid and ready are both high. in_ready never depends on in_valid in the
//   sequential build. Holding valid low (input side) or ready low (output
//   side) freezes the whole engine through dp_en, so no beat is lost or
//   duplicated.
//
//   Build option: define AES_SEQ_OVERLAP_EN to overlap the drain of one block
//   with the load of the next (one shared beat counter, both sides must be
//   ready for a beat to move). Undefined: drain and load are strictly
//   sequential.
//
// Parameters
//   BPC  bytes per cycle (1, 2 or 4)
//   NR   number of encryption rounds (1..14); the last one skips MixColumns
//
// Ports
//   clk, rst       clock, synchronous active-high reset
//   in_valid/in_ready    load-beat handshake (data+key beat from the source)
//   out_valid/out_ready  ciphertext-beat handshake towards the sink
//   dp_en          clock enable for every datapath/key register
//   input_sel      key mux: 0 = key_in, 1 = recirculated round key
//   sbox_sel       key S-box source: 1 = live byte, 0 = redundant register
//   last_out_sel   key last-column select
//   bit_out_sel    key output select
//   rcon_en[7:0]   0xFF on the round-constant injection cycle
//   pld            parallel load of the mixcolumn/shift-row register
//   mc_en[7:0]     0xFF = MixColumns active, 0x00 = bypass
//   rnd[3:0]       current round (0 while loading/draining)
//   blk_cnt[15:0]  completed blocks, wraps
//   done           one-cycle pulse after the last output beat
//   state[2:0]     debug view of the controller state
//   beat           debug view of the beat / round-cycle counter
// ----------------------------------------------------------------------------
module aes_serial_seq #(
   parameter int BPC = 1,
   parameter int NR  = 10
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          in_valid,
   output logic                          in_ready,
   output logic                          out_valid,
   input  logic                          out_ready,
   output logic                          dp_en,
   output logic                          input_sel,
   output logic                          sbox_sel,
   output logic                          last_out_sel,
   output logic                          bit_out_sel,
   output logic [7:0]                    rcon_en,
   output logic                          pld,
   output logic [7:0]                    mc_en,
   output logic [3:0]                    rnd,
   output logic [15:0]                   blk_cnt,
   output logic                          done,
   output logic [2:0]                    state,
   output logic [$clog2(16/BPC)-1:0]     beat
);

   localparam int BB  = 16 / BPC;        // beats per block (= cycles per round)
   localparam int CB  = 4 / BPC;         // beats per column
   localparam int BCW = $clog2(BB);

   localparam logic [BCW-1:0] BC_LAST   = BCW'(BB - 1);
   localparam logic [BCW-1:0] SBX_LAST  = BCW'(CB - 1);
   localparam logic [BCW-1:0] NORM_LAST = BCW'(3 * CB - 1);
   localparam logic [BCW-1:0] CB_MASK   = BCW'(CB - 1);
   localparam logic [3:0]     RND_LAST  = 4'(NR);

   if (!(BPC == 1 || BPC == 2 || BPC == 4)) begin : g_bad_bpc
      $error("aes_serial_seq: BPC must be 1, 2 or 4");
   end
   if (NR < 1 || NR > 14) begin : g_bad_nr
      $error("aes_serial_seq: NR must be in 1..14");
   end

   typedef enum logic [2:0] {
      S_LOAD = 3'd0,
      S_SBX  = 3'd1,
      S_NORM = 3'd2,
      S_SHIF = 3'd3,
      S_DRN  = 3'd4
   } state_t;

   state_t           st, st_n;
   logic [BCW-1:0]   bc, bc_n;
   logic [3:0]       rnd_q, rnd_n;
   logic [15:0]      blk_q, blk_n;
   logic             done_q, done_n;

   logic             in_ready_c, out_valid_c, dp_en_c, input_sel_c, sbox_sel_c;
   logic             last_c, bit_c, pld_c, bc_last, col_end, fire;
   logic [7:0]       rcon_c, mc_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         st     <= S_LOAD;
         bc     <= '0;
         rnd_q  <= '0;
         blk_q  <= '0;
         done_q <= 1'b0;
      end else begin
         st     <= st_n;
         bc     <= bc_n;
         rnd_q  <= rnd_n;
         blk_q  <= blk_n;
         done_q <= done_n;
      end
   end

   // Inside the rounds bc counts the cycle within the round (0..BB-1), so the
   // column position is simply its low bits.
   assign bc_last = (bc == BC_LAST);
   assign col_end = ((bc & CB_MASK) == CB_MASK);

   always_comb begin
      st_n        = st;
      bc_n        = bc;
      rnd_n       = rnd_q;
      blk_n       = blk_q;
      done_n      = 1'b0;
      in_ready_c  = 1'b0;
      out_valid_c = 1'b0;
      dp_en_c     = 1'b0;
      input_sel_c = 1'b1;
      sbox_sel_c  = 1'b1;
      last_c      = 1'b0;
      bit_c       = 1'b0;
      rcon_c      = 8'h00;
      pld_c       = 1'b0;
      fire        = 1'b0;

      case (st)
         S_LOAD: begin
            in_ready_c  = 1'b1;
            dp_en_c     = in_valid;
            input_sel_c = 1'b0;
            if (in_valid) begin
               bc_n = bc + 1'b1;
               if (bc_last) begin
                  st_n  = S_SBX;
                  rnd_n = 4'd1;
               end
            end
         end

         S_SBX: begin
            dp_en_c    = 1'b1;
            bit_c      = 1'b1;
            rcon_c     = (bc == '0) ? 8'hFF : 8'h00;
            // last SBX cycle takes the byte from the redundant register
            sbox_sel_c = (bc != SBX_LAST);
            pld_c      = col_end;
            bc_n       = bc + 1'b1;
            if (bc == SBX_LAST) st_n = S_NORM;
         end

         S_NORM: begin
            dp_en_c = 1'b1;
            last_c  = 1'b1;
            bit_c   = 1'b1;
            pld_c   = col_end;
            bc_n    = bc + 1'b1;
            if (bc == NORM_LAST) st_n = S_SHIF;
         end

         S_SHIF: begin
            dp_en_c = 1'b1;
            last_c  = 1'b1;
            pld_c   = col_end;
            bc_n    = bc + 1'b1;
            if (bc_last) begin
               if (rnd_q < RND_LAST) begin
                  st_n  = S_SBX;
                  rnd_n = rnd_q + 4'd1;
               end else begin
                  st_n  = S_DRN;
                  rnd_n = 4'd0;
               end
            end
         end

         S_DRN: begin
`ifdef AES_SEQ_OVERLAP_EN
            // The beat leaving is replaced by the next block's beat, so the
            // key mux takes key_in and both sides must agree to move.
            in_ready_c  = out_ready;
            out_valid_c = in_valid;
            dp_en_c     = in_valid & out_ready;
            input_sel_c = 1'b0;
            fire        = in_valid & out_ready;
`else
            out_valid_c = 1'b1;
            dp_en_c     = out_ready;
            fire        = out_ready;
`endif
            if (fire) begin
               bc_n = bc + 1'b1;
               if (bc_last) begin
                  done_n = 1'b1;
                  blk_n  = blk_q + 16'd1;
`ifdef AES_SEQ_OVERLAP_EN
                  st_n   = S_SBX;
                  rnd_n  = 4'd1;
`else
                  st_n   = S_LOAD;
`endif
               end
            end
         end

         default: begin
            st_n = S_LOAD;
            bc_n = '0;
         end
      endcase

      mc_c = (pld_c || (rnd_q == RND_LAST)) ? 8'h00 : 8'hFF;
   end

   // Everything reads zero during the reset cycle itself, whatever state the
   // registers held before the edge.
   assign in_ready     = ~rst & in_ready_c;
   assign out_valid    = ~rst & out_valid_c;
   assign dp_en        = ~rst & dp_en_c;
   assign input_sel    = ~rst & input_sel_c;
   assign sbox_sel     = ~rst & sbox_sel_c;
   assign last_out_sel = ~rst & last_c;
   assign bit_out_sel  = ~rst & bit_c;
   assign pld          = ~rst & pld_c;
   assign rcon_en      = rst ? 8'h00 : rcon_c;
   assign mc_en        = rst ? 8'h00 : mc_c;
   assign rnd          = rst ? 4'd0 : rnd_q;
   assign blk_cnt      = rst ? 16'd0 : blk_q;
   assign done         = ~rst & done_q;
   assign state        = rst ? 3'd0 : st;
   assign beat         = rst ? '0 : bc;

endmodule
